voice_sequencer: RTL and testbench

// Time-multiplexes one shared waveform ROM across N_VOICES key voices. Once per sample period it

---
 rtl/voice_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_voice_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_sequencer.sv
// voice_sequencer: shares one waveform ROM across N_VOICES key voices.
// Each sample period the key chord is latched. The active voices are then read
// in ascending order over a req/valid handshake, and their phases are advanced.
// The samples are summed, and one scaled mixed sample is emitted per period.
module voice_sequencer #(
  parameter int N_VOICES   = 8,
  parameter int PHASE_W    = 16,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int SAMPLE_DIV = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_VOICES-1:0]           keys,
  input  logic [N_VOICES*PHASE_W-1:0]   inc,
  output logic                          rom_req,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic                          rom_valid,
  input  logic [DATA_W-1:0]             rom_data,
  output logic [DATA_W-1:0]             wave,
  output logic                          sample_vld,
  output logic [$clog2(N_VOICES):0]     active_cnt,
  output logic                          overrun
);

  localparam int LOG_N = $clog2(N_VOICES);
  localparam int IDX_W = LOG_N + 1;
  localparam int ACC_W = DATA_W + LOG_N;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [LOG_N-1:0] LAST_VOICE = LOG_N'(N_VOICES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_OUTPUT = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [N_VOICES-1:0] chord_q, chord_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LOG_N-1:0]    voice_q, voice_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [PHASE_W-1:0]  phase_q [N_VOICES];
  logic [PHASE_W-1:0]  phase_d [N_VOICES];
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wave_q, wave_d;
  logic                vld_q, vld_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                ovr_q, ovr_d;

  logic [PHASE_W-1:0]  inc_arr [N_VOICES];
  logic                tick;
  logic                found;
  logic [LOG_N-1:0]    sel;
  logic [IDX_W-1:0]    keys_pop;

  // Unpack the flat increment bus into one word per voice
  generate
    for (genvar gi = 0; gi < N_VOICES; gi++) begin : g_inc
      assign inc_arr[gi] = inc[gi*PHASE_W +: PHASE_W];
    end
  endgenerate

  // Count pressed keys, and find the lowest chord voice at or above idx
  always_comb begin
    keys_pop = '0;
    found    = 1'b0;
    sel      = '0;
    for (int i = 0; i < N_VOICES; i++) begin
      keys_pop = keys_pop + IDX_W'(keys[i]);
    end
    for (int i = N_VOICES - 1; i >= 0; i--) begin
      if (chord_q[i] && (IDX_W'(i) >= idx_q)) begin
        found = 1'b1;
        sel   = LOG_N'(i);
      end
    end
  end

  // Next-state logic: divider, sticky overrun and the voice-walking FSM
  always_comb begin
    state_d = state_q;
    chord_d = chord_q;
    idx_d   = idx_q;
    voice_d = voice_q;
    acc_d   = acc_q;
    phase_d = phase_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wave_d  = wave_q;
    vld_d   = 1'b0;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;

    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_W'(1);
    // A tick that finds the FSM busy is dropped; the running sequence finishes
    if (tick && (state_q != S_IDLE)) ovr_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_LATCH;
      end
      S_LATCH: begin
        chord_d = keys;
        acc_d   = '0;
        idx_d   = '0;
        cnt_d   = keys_pop;
        // A released key restarts its note from phase 0
        for (int i = 0; i < N_VOICES; i++) begin
          if (!keys[i]) phase_d[i] = '0;
        end
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (found) begin
          voice_d = sel;
          addr_d  = phase_q[sel][PHASE_W-1 -: ADDR_W];
          req_d   = 1'b1;
          state_d = S_WAIT;
        end else begin
          state_d = S_OUTPUT;
        end
      end
      S_WAIT: begin
        if (rom_valid) begin
          acc_d            = acc_q + ACC_W'(rom_data);
          phase_d[voice_q] = phase_q[voice_q] + inc_arr[voice_q];
          req_d            = 1'b0;
          idx_d            = IDX_W'(voice_q) + IDX_W'(1);
          state_d          = (voice_q == LAST_VOICE) ? S_OUTPUT : S_ISSUE;
        end
      end
      S_OUTPUT: begin
        wave_d  = acc_q[ACC_W-1:LOG_N];
        vld_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      chord_q <= '0;
      idx_q   <= '0;
      voice_q <= '0;
      acc_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wave_q  <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < N_VOICES; i++) phase_q[i] <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      chord_q <= chord_d;
      idx_q   <= idx_d;
      voice_q <= voice_d;
      acc_q   <= acc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wave_q  <= wave_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      for (int i = 0; i < N_VOICES; i++) phase_q[i] <= phase_d[i];
    end
  end

  assign rom_req    = req_q;
  assign rom_addr   = addr_q;
  assign wave       = wave_q;
  assign sample_vld = vld_q;
  assign active_cnt = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_voice_sequencer.sv
// tb_voice_sequencer: scoreboard bench for voice_sequencer using a short sample period.
// A ROM responder with programmable latency answers requests.
// A reference model queues the expected addresses and mixed samples.
module tb_voice_sequencer;
  localparam int NV   = 8;
  localparam int PW   = 16;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int SDIV = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NV-1:0]     keys = 8'hFF;
  logic [NV*PW-1:0]  inc;
  logic              rom_req;
  logic [AW-1:0]     rom_addr;
  logic              rom_valid = 1'b0;
  logic [DW-1:0]     rom_data = '0;
  logic [DW-1:0]     wave;
  logic              sample_vld;
  logic [3:0]        active_cnt;
  logic              overrun;

  voice_sequencer #(
    .N_VOICES(NV), .PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW), .SAMPLE_DIV(SDIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .inc(inc),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_valid(rom_valid), .rom_data(rom_data),
    .wave(wave), .sample_vld(sample_vld), .active_cnt(active_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] wave;
    logic [3:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] addr_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         vld_cnt = 0;
  int         cyc = 0;
  int         last_vld = -1;
  bit         per_chk = 0;
  int         rom_lat = 1;
  int         rom_cnt = 0;
  bit         rom_mode = 0;
  logic [7:0] rom_const = 8'h00;
  bit         late_pulse = 0;
  logic [PW-1:0] m_phase [NV];
  logic [PW-1:0] m_inc [NV];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    return rom_mode ? (a ^ 8'hA5) : rom_const;
  endfunction

  // ROM responder and output scoreboard, both on the falling edge
  always @(negedge clk) begin : neg_proc
    exp_t e;
    cyc++;
    if (sample_vld) begin
      vld_cnt++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_sample", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("wave", wave, e.wave);
        check_val("active_cnt", active_cnt, e.cnt);
      end
      if (per_chk) begin
        if (last_vld >= 0) check_val("vld_period", cyc - last_vld, SDIV);
        last_vld = cyc;
      end
    end
    if (!per_chk) last_vld = -1;

    if (rom_req && !rom_valid) begin
      if (rom_cnt == 0) begin
        if (addr_q.size() == 0) check_val("unexpected_req", 1, 0);
        else check_val("rom_addr", rom_addr, addr_q.pop_front());
      end
      rom_cnt++;
      if (rom_cnt == rom_lat) begin
        rom_valid = 1'b1;
        rom_data  = rom_fn(rom_addr);
      end
    end else begin
      rom_cnt   = 0;
      rom_valid = late_pulse;
      rom_data  = late_pulse ? 8'hFF : 8'h00;
    end
  end

  task automatic model_clear();
    for (int v = 0; v < NV; v++) m_phase[v] = '0;
  endtask

  // Reset for two cycles, checking that the outputs sit at zero on each cycle
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check_val("rst_wave", wave, 0);
      check_val("rst_rom_req", rom_req, 0);
      check_val("rst_sample_vld", sample_vld, 0);
      check_val("rst_overrun", overrun, 0);
      check_val("rst_active_cnt", active_cnt, 0);
    end
    check_val("leftover_addr", addr_q.size(), 0);
    check_val("leftover_wave", exp_q.size(), 0);
    addr_q.delete();
    exp_q.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Model n sample periods with chord k, pushing expected addresses and samples
  task automatic plan(input logic [7:0] k, input int n);
    int   acc;
    exp_t e;
    logic [7:0] a;
    for (int p = 0; p < n; p++) begin
      acc = 0;
      for (int v = 0; v < NV; v++) if (!k[v]) m_phase[v] = '0;
      for (int v = 0; v < NV; v++) begin
        if (k[v]) begin
          a = m_phase[v][PW-1 -: AW];
          addr_q.push_back(a);
          acc = acc + int'(rom_fn(a));
          m_phase[v] = m_phase[v] + m_inc[v];
        end
      end
      e.wave = 8'(acc >> 3);
      e.cnt  = 4'($countones(k));
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_vld(input int target);
    int t = 0;
    while (vld_cnt < target && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (vld_cnt < target) check_val("vld_timeout", vld_cnt, target);
  endtask

  task automatic run(input logic [7:0] k, input int n);
    int target;
    target = vld_cnt + n;
    plan(k, n);
    @(negedge clk);
    keys = k;
    wait_vld(target);
  endtask

  initial begin
    int t;
    for (int v = 0; v < NV; v++) begin
      m_inc[v] = 16'h0100 * 16'(v + 1) + 16'h0037 * 16'(v);
      inc[v*PW +: PW] = m_inc[v];
    end

    // Reset with all keys held
    keys = 8'hFF;
    do_reset();

    // Single voice, unit increment, constant ROM, latency 1
    rom_lat = 1; rom_mode = 0; rom_const = 8'h40;
    run(8'h01, 3);
    check_val("overrun_single", overrun, 0);

    // Full chord at full scale
    do_reset();
    rom_const = 8'hFF;
    run(8'hFF, 2);

    // No keys: periodic empty samples
    do_reset();
    per_chk = 1;
    run(8'h00, 4);
    per_chk = 0;

    // Slow ROM overruns the short period; then release and re-press key 0
    do_reset();
    rom_lat = 3; rom_mode = 1;
    run(8'hFF, 3);
    check_val("overrun_slow", overrun, 1);
    run(8'hFE, 1);
    run(8'hFF, 1);
    check_val("overrun_sticky", overrun, 1);

    // Reset in the middle of a ROM wait, followed by a stray valid
    do_reset();
    rom_lat = 6; rom_mode = 0; rom_const = 8'h40;
    addr_q.push_back(8'h00);
    @(negedge clk);
    keys = 8'h01;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!rom_req && t < 100);
    check_val("req_seen", rom_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("rst_req_drop", rom_req, 0);
    rst_n = 1'b1;
    late_pulse = 1'b1;
    @(posedge clk); #1;
    late_pulse = 1'b0;
    model_clear();
    rom_lat = 1;
    run(8'h01, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
